// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle logic/arith ops and an
// iterative shift-and-add multiplier that holds the input side off while it runs.
module seq_alu #(
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_carry_out,
  output logic             o_busy
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               r_state, w_state_next;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_mcand, r_acc, w_acc_add;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_result;
  logic                 r_out_valid, r_zero, r_ovf, r_cy;
  logic                 w_accept, w_last, w_sub, w_add_ovf;
  logic [WIDTH-1:0]     w_b_op, w_alu_res;
  logic [WIDTH:0]       w_sum;
  logic                 w_alu_ovf, w_alu_cy;

  assign o_in_ready  = (r_state == S_IDLE) && (!r_out_valid || i_out_ready);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_last      = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));
  assign o_busy      = (r_state == S_MUL);
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_overflow  = r_ovf;
  assign o_carry_out = r_cy;

  // SUB is A + ~B + 1; signed overflow when operands agree in sign but the sum does not
  assign w_sub     = (i_op == OP_SUB);
  assign w_b_op    = w_sub ? ~i_b : i_b;
  assign w_sum     = {1'b0, i_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};
  assign w_add_ovf = (i_a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
  assign w_acc_add = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_cy  = 1'b0;
    case (i_op)
      OP_AND: w_alu_res = i_a & i_b;
      OP_OR:  w_alu_res = i_a | i_b;
      OP_ADD, OP_SUB: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_ovf = w_add_ovf;
        w_alu_cy  = w_sum[WIDTH];
      end
      OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_XOR: w_alu_res = i_a ^ i_b;
      OP_NOR: w_alu_res = ~(i_a | i_b);
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (i_op == OP_MUL)) w_state_next = S_MUL;
      S_MUL:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_cy        <= 1'b0;
    end else begin
      if (w_accept) begin
        if (i_op == OP_MUL) begin
          r_mcand     <= {{WIDTH{1'b0}}, i_a};
          r_mplier    <= i_b;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_result    <= w_alu_res;
          r_zero      <= (w_alu_res == '0);
          r_ovf       <= w_alu_ovf;
          r_cy        <= w_alu_cy;
          r_out_valid <= 1'b1;
        end
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      // one partial product per cycle; the final add lands straight in the result
      if (r_state == S_MUL) begin
        r_acc    <= w_acc_add;
        r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          r_result    <= w_acc_add[WIDTH-1:0];
          r_zero      <= (w_acc_add[WIDTH-1:0] == '0);
          r_ovf       <= |w_acc_add[2*WIDTH-1:WIDTH];
          r_cy        <= 1'b0;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [2:0]   op;
  logic         zero, ovf, cy, busy;
  int           n_checks = 0;
  int           n_errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_op(op), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_result(result), .o_zero(zero), .o_overflow(ovf), .o_carry_out(cy), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sext(input logic [63:0] x);
    return x[W-1] ? longint'(x) - (longint'(1) <<< W) : longint'(x);
  endfunction

  function automatic void model(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic z, output logic v, output logic c);
    logic [63:0] mask, full;
    longint s, smax, smin;
    mask = (64'd1 << W) - 64'd1;
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    r = '0; v = 1'b0; c = 1'b0; full = '0; s = 0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: begin full = x + y; s = sext(x) + sext(y); end
      3'd3: begin full = x + (~y & mask) + 64'd1; s = sext(x) - sext(y); end
      3'd4: r = (sext(x) < sext(y)) ? 64'd1 : 64'd0;
      3'd5: r = x ^ y;
      3'd6: begin full = x * y; r = full & mask; v = (full >> W) != 0; end
      default: r = ~(x | y) & mask;
    endcase
    if (o == 3'd2 || o == 3'd3) begin
      r = full & mask;
      c = full[W];
      v = (s > smax) || (s < smin);
    end
    z = (r == 0);
  endfunction

  // Issue one bundle with out_ready=1 and check the returned result and its timing
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] er;
    logic ez, ev, ec;
    int n, busy_n;
    bit rdy_seen;
    model(o, 64'(x), 64'(y), er, ez, ev, ec);
    check("in_ready_pre", in_ready, 1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    if (o == 3'd6) begin
      n = 0; busy_n = 0; rdy_seen = 0;
      check("mul_ov_start", out_valid, 0);
      while (!out_valid && n < 200) begin
        busy_n += int'(busy);
        if (in_ready) rdy_seen = 1;
        a = W'($urandom); b = W'($urandom); op = 3'($urandom); in_valid = 1'b1;
        @(posedge clk); #1;
        n++;
      end
      in_valid = 1'b0;
      check("mul_latency", 64'(n), 64'(W));
      check("mul_busy_cycles", 64'(busy_n), 64'(W));
      check("mul_in_ready_low", 64'(rdy_seen), 0);
      check("mul_busy_end", busy, 0);
    end else begin
      check("out_valid", out_valid, 1);
    end
    check("result", 64'(result), er);
    check("zero", zero, ez);
    check("overflow", ovf, ev);
    check("carry", cy, ec);
    $display("op=%0d a=%06h b=%06h result=%06h z=%0b v=%0b c=%0b", o, x, y, result, zero, ovf, cy);
  endtask

  initial begin
    logic [63:0] er1, er2;
    logic ez, ev, ec;
    logic [2:0] ro;
    logic [W-1:0] rx, ry, c1, d1;
    bit seen;
    logic [W-1:0] corner [4];
    corner[0] = 24'h7FFFFF; corner[1] = 24'h800000; corner[2] = 24'h000000; corner[3] = 24'hFFFFFF;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", 64'(result), 0);
    check("rst_flags", {zero, ovf, cy}, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    do_op(3'd2, 24'h7FFFFF, 24'h000001);
    do_op(3'd3, 24'h123456, 24'h123456);
    do_op(3'd4, 24'h800000, 24'h000001);
    do_op(3'd4, 24'h000001, 24'h800000);
    do_op(3'd6, 24'h001000, 24'h001000);
    do_op(3'd6, 24'h000ABC, 24'h000123);

    // backpressure: hold an ADD result for 5 cycles, then consume and accept together
    do_op(3'd2, 24'h00F00F, 24'h0A0A0A);
    model(3'd2, 64'h00F00F, 64'h0A0A0A, er1, ez, ev, ec);
    c1 = W'($urandom); d1 = W'($urandom);
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd3;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 0);
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check("bp_hold_result", 64'(result), er1);
      check("bp_hold_valid", out_valid, 1);
    end
    a = c1; b = d1; op = 3'd3; out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    model(3'd3, 64'(c1), 64'(d1), er2, ez, ev, ec);
    @(posedge clk); #1;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_result", 64'(result), er2);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("consume_drop", out_valid, 0);

    for (int i = 0; i < 120; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      do_op(ro, rx, ry);
    end

    // reset partway through a multiply discards it
    do_op(3'd2, 24'h000005, 24'h000006);
    in_valid = 1'b1; op = 3'd6; a = 24'h00ABCD; b = 24'h001234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_mul_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mmr_busy", busy, 0);
    check("mmr_out_valid", out_valid, 0);
    check("mmr_result", 64'(result), 0);
    check("mmr_flags", {zero, ovf, cy}, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1;
    end
    check("mmr_no_valid", 64'(seen), 0);
    do_op(3'd0, 24'hF0F0F0, 24'h0FF0FF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24: operand and result width in bits; legal values are 4 to 64.
REQ-002 Clock  input  1  rising-edge clock; the only clock in the block.
REQ-003 Reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of Clock.
REQ-004 InValid  input  1  operand/op bundle is valid this cycle.
REQ-005 InReady  output  1  the block accepts the bundle this cycle.
REQ-006 A, B  input  WIDTH each  operands.
REQ-007 Op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (signed), 101 XOR, 110 MUL (iterative), 111 NOR.
REQ-008 OutValid  output  1  Result and flags are valid.
REQ-009 OutReady  input  1  downstream consumes the output this cycle.
REQ-010 Result  output  WIDTH  registered result.
REQ-011 Zero, Overflow, CarryOUT  output  1 each  registered flags.
REQ-012 Busy  output  1  a multiply is in progress.

Function
REQ-013 Accept: an input transfer SHALL occur when InValid=1 and InReady=1 on the same rising edge.
REQ-014 InReady SHALL equal (state==IDLE) AND (OutValid==0 OR OutReady==1).
REQ-015 Output transfer: an output transfer SHALL occur when OutValid=1 and OutReady=1 on the same rising edge.
REQ-016 Output hold: Result, flags and OutValid SHALL hold stable while OutValid=1 and OutReady=0.
REQ-017 The FSM SHALL have two states, IDLE and MUL.
REQ-018 IDLE->MUL: on an accepted bundle with Op=110; the block latches A and B.
REQ-019 MUL->IDLE: after exactly WIDTH iterations of shift-and-add, one iteration per cycle.
REQ-020 Non-MUL latency: OutValid SHALL rise on the edge that accepts the bundle, i.e. 1-cycle latency.
REQ-021 MUL latency: OutValid SHALL rise WIDTH cycles after the accept edge.
REQ-022 Busy SHALL be 1 exactly while state==MUL.
REQ-023 Back-to-back: a new bundle may be accepted on the same edge that consumes the previous output, sustaining 1 op/cycle for non-MUL ops.
REQ-024 OutValid SHALL fall on a consume edge with no new accept.
REQ-025 ADD/SUB: Result = (A + B) or (A + ~B + 1), modulo 2^WIDTH.
REQ-026 ADD/SUB CarryOUT SHALL be the carry out of bit WIDTH-1, so SUB CarryOUT=1 means no borrow.
REQ-027 ADD/SUB Overflow SHALL be the signed overflow, i.e. the carry into the MSB XOR the carry out of the MSB.
REQ-028 SLT: Result = 1 if signed(A) < signed(B), else 0; SLT SHALL be correct even when A-B overflows.
REQ-029 MUL: Result SHALL be the low WIDTH bits of the unsigned product A*B.
REQ-030 MUL Overflow SHALL be 1 iff the high WIDTH bits of the product are nonzero.
REQ-031 CarryOUT SHALL be 0 for every op other than ADD/SUB; Overflow SHALL be 0 for every op other than ADD/SUB/MUL.
REQ-032 Zero SHALL be 1 iff Result==0, for every op.
REQ-033 Operand changes on A/B/Op SHALL NOT affect an in-progress multiply.
REQ-034 Operand changes on A/B/Op SHALL NOT affect a held output.
REQ-035 InValid while Busy=1 SHALL be ignored; the bundle is not accepted and no state changes.
REQ-036 A MUL SHALL NOT begin until the prior output is consumed, or is being consumed on that same edge (per REQ-014).

Reset
REQ-037 On a rising edge with Reset_n=0: state=IDLE; OutValid, Busy, Result, Zero, Overflow and CarryOUT SHALL all be 0.
REQ-038 Reset mid-multiply or with an output held SHALL discard the operation; no OutValid pulse follows reset release.
REQ-039 InReady SHALL be 1 on the first edge after reset release, per REQ-014.

Verification (WIDTH=24)
REQ-040 Add overflow: ADD A=7FFFFF, B=000001, OutReady=1 -> next cycle Result=800000, Overflow=1, CarryOUT=0, Zero=0.
REQ-041 Equal subtract: SUB A=B=123456 -> Result=0, Zero=1, CarryOUT=1, Overflow=0.
REQ-042 Signed compare: SLT A=800000, B=000001 -> Result=1; SLT A=000001, B=800000 -> Result=0.
REQ-043 Multiply: MUL A=001000, B=001000 -> Busy=1 for 24 cycles, InReady=0 throughout, OutValid on cycle 24, Result=000000, Overflow=1, Zero=1.
REQ-044 Backpressure: OutReady=0 for 5 cycles after an ADD -> Result held stable, InReady=0; raising OutReady with InValid=1 -> consume and accept on the same edge, and the next result follows 1 cycle later.
REQ-045 Reset mid-multiply: assert Reset_n=0 at cycle 10 of a MUL -> all outputs 0, Busy=0, and no OutValid afterward until a new accept.
